spi_reg_responder: RTL and testbench

SPI mode-0 responder with a 32×8 register file. It is the far end of the system's SPI master (MOSI/SCLK/SS_n driven, MISO sampled) and answers with a MAX3421E-style command/status framing. It serves two purposes:
- Bench target for the SPI master path.
- Soft peripheral hung on the same SPI wires, so local logic can exchange bytes with the processor without the USB controller.

All SPI inputs are oversampled in the system clock domain. No logic runs on SCLK.

---
 rtl/spi_reg_responder.sv | 157 +++++++++++++++
 tb/tb_spi_reg_responder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_responder.sv
`default_nettype none
// ============================================================================
// Module   : spi_reg_responder
// Brief    : SPI mode-0 responder, 32x8 register file, command/status framing,
//            fully oversampled in the system clock domain.
// Revision : 1.0
// ============================================================================
module spi_reg_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic       spi_SCLK,
    input  logic       spi_MOSI,
    input  logic       spi_SS_n,
    output logic       spi_MISO,
    input  logic [7:0] status_in,
    output logic       reg_wr_valid,
    output logic [4:0] reg_wr_addr,
    output logic [7:0] reg_wr_data,
    input  logic [4:0] loc_rd_addr,
    output logic [7:0] loc_rd_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMD  = 2'd1,
        S_DATA = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_ss_sync;
    logic                   r_sclk_d;
    logic                   r_ss_d;

    state_t      r_state;
    logic [2:0]  r_bit_cnt;
    logic [6:0]  r_rx_shift;
    logic [7:0]  r_tx_shift;
    logic [4:0]  r_addr;
    logic        r_wr;
    logic        r_wr_valid;
    logic [4:0]  r_wr_addr;
    logic [7:0]  r_wr_data;
    logic [7:0]  r_regs [32];

    logic        w_sclk;
    logic        w_mosi;
    logic        w_ss;
    logic        w_sclk_rise;
    logic        w_sclk_fall;
    logic        w_ss_fall;
    logic        w_byte_done;
    logic [7:0]  w_rx_byte;
    logic [7:0]  w_load_byte;
    logic [7:0]  w_tx_next;

    // SS_n synchronizer resets high so leaving reset never looks like a select.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_ss_sync   <= '1;
            r_sclk_d    <= 1'b0;
            r_ss_d      <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_SCLK};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_MOSI};
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], spi_SS_n};
            r_sclk_d    <= w_sclk;
            r_ss_d      <= w_ss;
        end
    end

    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_ss        = r_ss_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk & r_sclk_d;
    assign w_ss_fall   = ~w_ss & r_ss_d;

    assign w_rx_byte   = {r_rx_shift, w_mosi};
    assign w_byte_done = w_sclk_rise && (r_bit_cnt == 3'd7) && (r_state != S_IDLE);
    assign w_load_byte = (r_state == S_DATA && !r_wr) ? r_regs[r_addr] : 8'h00;
    assign w_tx_next   = (r_bit_cnt == 3'd0) ? w_load_byte : {r_tx_shift[6:0], 1'b0};

    // A byte finishing in the same cycle as deselect is still committed.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_state    <= S_IDLE;
            r_bit_cnt  <= 3'd0;
            r_rx_shift <= 7'd0;
            r_tx_shift <= 8'd0;
            r_addr     <= 5'd0;
            r_wr       <= 1'b0;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= 5'd0;
            r_wr_data  <= 8'd0;
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= 8'h00;
            end
        end else begin
            r_wr_valid <= 1'b0;
            if (w_sclk_rise && r_state != S_IDLE) begin
                r_rx_shift <= w_rx_byte[6:0];
                r_bit_cnt  <= r_bit_cnt + 3'd1;
            end
            if (w_byte_done) begin
                if (r_state == S_CMD) begin
                    r_addr <= w_rx_byte[7:3];
                    r_wr   <= w_rx_byte[1];
                end else begin
                    if (r_wr) begin
                        r_regs[r_addr] <= w_rx_byte;
                        r_wr_valid     <= 1'b1;
                        r_wr_addr      <= r_addr;
                        r_wr_data      <= w_rx_byte;
                    end
                    r_addr <= r_addr + 5'd1;
                end
            end
            if (w_ss) begin
                r_state    <= S_IDLE;
                r_bit_cnt  <= 3'd0;
                r_tx_shift <= 8'd0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_ss_fall) begin
                            r_state    <= S_CMD;
                            r_bit_cnt  <= 3'd0;
                            r_tx_shift <= status_in;
                        end
                    end
                    S_CMD, S_DATA: begin
                        if (w_byte_done && r_state == S_CMD) begin
                            r_state <= S_DATA;
                        end
                        if (w_sclk_fall) begin
                            r_tx_shift <= w_tx_next;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign spi_MISO     = r_tx_shift[7];
    assign reg_wr_valid = r_wr_valid;
    assign reg_wr_addr  = r_wr_addr;
    assign reg_wr_data  = r_wr_data;
    assign loc_rd_data  = r_regs[loc_rd_addr];

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_reg_responder
// Brief    : Directed frame table plus abort, reset and burst sequences.
// Revision : 1.0
// ============================================================================
module tb_spi_reg_responder;

    logic       clk_clk = 1'b0;
    logic       reset_reset = 1'b1;
    logic       spi_SCLK = 1'b0;
    logic       spi_MOSI = 1'b0;
    logic       spi_SS_n = 1'b1;
    logic       spi_MISO;
    logic [7:0] status_in = 8'h00;
    logic       reg_wr_valid;
    logic [4:0] reg_wr_addr;
    logic [7:0] reg_wr_data;
    logic [4:0] loc_rd_addr = 5'd0;
    logic [7:0] loc_rd_data;

    spi_reg_responder #(.SYNC_STAGES(2)) dut (
        .clk_clk      (clk_clk),
        .reset_reset  (reset_reset),
        .spi_SCLK     (spi_SCLK),
        .spi_MOSI     (spi_MOSI),
        .spi_SS_n     (spi_SS_n),
        .spi_MISO     (spi_MISO),
        .status_in    (status_in),
        .reg_wr_valid (reg_wr_valid),
        .reg_wr_addr  (reg_wr_addr),
        .reg_wr_data  (reg_wr_data),
        .loc_rd_addr  (loc_rd_addr),
        .loc_rd_data  (loc_rd_data)
    );

    always #5 clk_clk = ~clk_clk;

    typedef struct {
        int          n;
        logic [7:0]  status;
        logic [31:0] mosi;
        logic [31:0] miso;
    } vec_t;

    vec_t        vecs [7];
    int          tests = 0;
    int          fails = 0;
    int          half = 6;
    logic [7:0]  model [32];
    logic [4:0]  q_addr [$];
    logic [7:0]  q_data [$];
    logic [7:0]  burst [16];
    logic [7:0]  rb;
    logic [7:0]  cmd;
    logic [4:0]  a;

    always @(negedge clk_clk) begin
        if (reg_wr_valid) begin
            q_addr.push_back(reg_wr_addr);
            q_data.push_back(reg_wr_data);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk_clk);
    endtask

    task automatic xfer_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int b = 7; b >= 8 - nbits; b--) begin
            spi_MOSI = tx[b];
            wait_clk(half);
            rx[b]    = spi_MISO;
            spi_SCLK = 1'b1;
            wait_clk(half);
            spi_SCLK = 1'b0;
        end
    endtask

    task automatic begin_frame();
        spi_SS_n = 1'b0;
        wait_clk(4);
    endtask

    task automatic end_frame();
        wait_clk(half);
        spi_SS_n = 1'b1;
        wait_clk(6);
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 32; i++) begin
            loc_rd_addr = 5'(i);
            #1;
            check($sformatf("%s_reg%0d", tag, i), {24'd0, loc_rd_data}, {24'd0, model[i]});
        end
    endtask

    task automatic check_pulse_count(input string tag, input int exp);
        check($sformatf("%s_pulses", tag), q_addr.size(), exp);
    endtask

    initial begin
        vecs[0] = '{3, 8'hA5, 32'h2A112200, 32'hA5000000};
        vecs[1] = '{3, 8'hA5, 32'h28000000, 32'hA5112200};
        vecs[2] = '{3, 8'hA5, 32'hFA778800, 32'hA5000000};
        vecs[3] = '{4, 8'hA5, 32'hF8000000, 32'hA5778800};
        vecs[4] = '{2, 8'h3C, 32'h00000000, 32'h3C880000};
        vecs[5] = '{2, 8'hC3, 32'h2F5A0000, 32'hC3000000};
        vecs[6] = '{3, 8'h01, 32'h2D000000, 32'h015A2200};
        for (int i = 0; i < 32; i++) model[i] = 8'h00;

        // Reset state
        wait_clk(3);
        check("rst_miso", {31'd0, spi_MISO}, 32'd0);
        check("rst_valid", {31'd0, reg_wr_valid}, 32'd0);
        reset_reset = 1'b0;
        wait_clk(4);
        check("init_addr", {27'd0, reg_wr_addr}, 32'd0);
        check("init_data", {24'd0, reg_wr_data}, 32'd0);
        check_regs("init");

        // Table of complete frames
        for (int k = 0; k < 7; k++) begin
            status_in = vecs[k].status;
            q_addr.delete();
            q_data.delete();
            begin_frame();
            for (int i = 0; i < vecs[k].n; i++) begin
                xfer_bits(vecs[k].mosi[31-8*i -: 8], 8, rb);
                check($sformatf("v%0d_miso%0d", k, i), {24'd0, rb},
                      {24'd0, vecs[k].miso[31-8*i -: 8]});
            end
            end_frame();
            cmd = vecs[k].mosi[31:24];
            if (cmd[1]) begin
                check_pulse_count($sformatf("v%0d", k), vecs[k].n - 1);
                for (int i = 0; i < vecs[k].n - 1; i++) begin
                    a = cmd[7:3] + 5'(i);
                    model[a] = vecs[k].mosi[23-8*i -: 8];
                    if (i < q_addr.size()) begin
                        check($sformatf("v%0d_waddr%0d", k, i), {27'd0, q_addr[i]}, {27'd0, a});
                        check($sformatf("v%0d_wdata%0d", k, i), {24'd0, q_data[i]}, {24'd0, model[a]});
                    end
                end
            end else begin
                check_pulse_count($sformatf("v%0d", k), 0);
            end
        end
        check_regs("table");

        // Deselect after 4 bits of the second data byte
        status_in = 8'h00;
        q_addr.delete();
        q_data.delete();
        begin_frame();
        xfer_bits(8'h52, 8, rb);
        xfer_bits(8'h99, 8, rb);
        xfer_bits(8'h66, 4, rb);
        end_frame();
        check_pulse_count("abort", 1);
        if (q_addr.size() > 0) begin
            check("abort_waddr", {27'd0, q_addr[0]}, 32'd10);
            check("abort_wdata", {24'd0, q_data[0]}, 32'h99);
        end
        model[10] = 8'h99;
        loc_rd_addr = 5'd11;
        #1;
        check("abort_reg11", {24'd0, loc_rd_data}, 32'h00);
        loc_rd_addr = 5'd10;
        #1;
        check("abort_reg10", {24'd0, loc_rd_data}, 32'h99);

        // Reset after 5 bits of a frame whose status keeps MISO high
        status_in = 8'hFF;
        begin_frame();
        xfer_bits(8'h12, 5, rb);
        reset_reset = 1'b1;
        spi_SS_n    = 1'b1;
        spi_SCLK    = 1'b0;
        wait_clk(2);
        check("mid_rst_miso", {31'd0, spi_MISO}, 32'd0);
        check("mid_rst_valid", {31'd0, reg_wr_valid}, 32'd0);
        check("mid_rst_waddr", {27'd0, reg_wr_addr}, 32'd0);
        check("mid_rst_wdata", {24'd0, reg_wr_data}, 32'd0);
        reset_reset = 1'b0;
        wait_clk(4);
        for (int i = 0; i < 32; i++) model[i] = 8'h00;
        check_regs("mid_rst");

        // 16-byte write then read burst at the minimum oversample ratio
        half = 4;
        status_in = 8'h5A;
        q_addr.delete();
        q_data.delete();
        for (int i = 0; i < 16; i++) burst[i] = 8'h3C ^ 8'(i * 37);
        begin_frame();
        xfer_bits(8'h82, 8, rb);
        check("burst_wr_status", {24'd0, rb}, 32'h5A);
        for (int i = 0; i < 16; i++) xfer_bits(burst[i], 8, rb);
        end_frame();
        check_pulse_count("burst", 16);
        for (int i = 0; i < 16; i++) begin
            if (i < q_addr.size()) begin
                check($sformatf("burst_waddr%0d", i), {27'd0, q_addr[i]}, 32'(16 + i));
                check($sformatf("burst_wdata%0d", i), {24'd0, q_data[i]}, {24'd0, burst[i]});
            end
        end
        begin_frame();
        xfer_bits(8'h80, 8, rb);
        check("burst_rd_status", {24'd0, rb}, 32'h5A);
        for (int i = 0; i < 16; i++) begin
            xfer_bits(8'h00, 8, rb);
            check($sformatf("burst_rd%0d", i), {24'd0, rb}, {24'd0, burst[i]});
        end
        end_frame();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
